ex_mem_stage: RTL and testbench

- Parametrised, handshaked execute/memory stage for the processor datapath.
- Selects ALU operand B from rd2 or the immediate, computes a WIDTH-bit ALU result with zero/negative flags, and performs a word-addressed data-memory read or write.
- Read latency is configurable. Results are registered and held until the downstream stage accepts them.
- Sits between decode/register-read and write-back; replaces the fixed 32-bit, non-handshaked execute block.

---
 rtl/ex_pkg.sv | 19 +
 rtl/ex_mem_stage_alu_core.sv | 30 +++
 rtl/ex_mem_stage.sv | 138 +++++++++++++
 tb/tb_ex_mem_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute/memory stage.
// ALU opcodes, FSM state type, read-latency ceiling.
package ex_pkg;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_NEG  = 3'b010;
  localparam logic [2:0] ALU_INC  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;

  localparam int MEM_LAT_MAX = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

endpackage

// File: rtl/ex_mem_stage_alu_core.sv
// Combinational ALU: result = f(op, a, b), plus zero/neg flags.
// Ports: a, b, op in; result, zero, neg out.
module alu_core
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg
);

  always_comb begin
    result = b;
    case (op)
      ALU_SUB: result = a - b;
      ALU_NEG: result = '0 - b;
      ALU_INC: result = a + WIDTH'(1);
      ALU_ADD: result = a + b;
      default: result = b;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[WIDTH-1];

endmodule

// File: rtl/ex_mem_stage.sv
// Handshaked execute/memory stage: ALU, data memory, result hold.
// Ports: clock/reset, in_valid/in_ready + op fields, out_valid/out_ready + results.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mem_write,
  input  logic             mem_read,
  input  logic             alu_src,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] read_data,
  output logic             zero,
  output logic             neg
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(MEM_DEPTH);
  localparam bit HAS_WAIT = (MEM_LATENCY > 0);
  localparam logic [2:0] WAIT_INIT =
    3'(HAS_WAIT ? MEM_LATENCY - 1 : 0);

  state_t state, state_nxt;

  logic             accept;
  logic             wait_read;
  logic [2:0]       cnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] raddr_q;
  logic             in_range;
  logic             in_range_q;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             alu_neg;
  logic [WIDTH-1:0] read_now;
  logic [WIDTH-1:0] mem [MEM_DEPTH];

  assign op_b      = alu_src ? imm : rd2;
  assign addr      = rd1[ADDR_W-1:0];
  assign in_range  = (rd1 < DEPTH_W);
  assign accept    = in_valid && in_ready;
  assign wait_read = mem_read && HAS_WAIT;

  // Write-first: a same-op store is what the load returns.
  assign read_now = !in_range ? '0 :
                    mem_write ? rd2 : mem[addr];

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a      (rd1),
    .b      (op_b),
    .op     (alu_op),
    .result (alu_res),
    .zero   (alu_zero),
    .neg    (alu_neg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_HOLD: begin
        if (accept)
          state_nxt = wait_read ? ST_MEM_WAIT : ST_HOLD;
        else if (state == ST_HOLD && out_ready)
          state_nxt = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        if (cnt == 3'd0) state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE: in_ready = !reset;
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !reset;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result     <= '0;
      read_data  <= '0;
      zero       <= 1'b0;
      neg        <= 1'b0;
      cnt        <= 3'd0;
      raddr_q    <= '0;
      in_range_q <= 1'b0;
    end else if (accept) begin
      result <= alu_res;
      zero   <= alu_zero;
      neg    <= alu_neg;
      if (wait_read) begin
        cnt        <= WAIT_INIT;
        raddr_q    <= addr;
        in_range_q <= in_range;
      end else begin
        read_data <= mem_read ? read_now : '0;
      end
    end else if (state == ST_MEM_WAIT) begin
      // Store of a read+write op already landed at accept.
      if (cnt == 3'd0)
        read_data <= in_range_q ? mem[raddr_q] : '0;
      else
        cnt <= cnt - 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept && mem_write && in_range)
      mem[addr] <= rd2;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage (MEM_DEPTH=64, MEM_LATENCY=3).
// Driver pushes model results; negedge monitor compares them.
module tb_ex_mem_stage;

  localparam int W     = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LAT   = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_write = 1'b0;
  logic          mem_read = 1'b0;
  logic          alu_src = 1'b0;
  logic [2:0]    alu_op = 3'd0;
  logic [W-1:0]  rd1 = '0;
  logic [W-1:0]  rd2 = '0;
  logic [W-1:0]  imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [W-1:0]  read_data;
  logic          zero;
  logic          neg;

  always #5 clock = ~clock;

  ex_mem_stage #(
    .WIDTH(W), .MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_write(mem_write), .mem_read(mem_read),
    .alu_src(alu_src), .alu_op(alu_op),
    .rd1(rd1), .rd2(rd2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .read_data(read_data),
    .zero(zero), .neg(neg)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] rdat;
    logic        z;
    logic        n;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  logic [31:0] mref [DEPTH];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int bp_mode = 0;
  bit fresh = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #2;
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  function automatic logic [31:0] alu_ref(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd1: return a - b;
      3'd2: return 32'd0 - b;
      3'd3: return a + 32'd1;
      3'd4: return a + b;
      default: return b;
    endcase
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_output: got result %h want none", result);
        fresh = out_ready;
      end else begin
        if (fresh) chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        chk("result", result, sb[0].res);
        chk("read_data", read_data, sb[0].rdat);
        chk("zero", 32'(zero), 32'(sb[0].z));
        chk("neg", 32'(neg), 32'(sb[0].n));
        if (out_ready) begin
          void'(sb.pop_front());
          fresh = 1'b1;
        end else begin
          fresh = 1'b0;
        end
      end
    end else begin
      fresh = 1'b1;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input bit w, input bit r, input bit s,
                       input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] i,
                       output int acc);
    exp_t e;
    logic [31:0] bb;
    bit inr;
    bit done;
    done = 1'b0;
    acc = -1;
    mem_write = w; mem_read = r; alu_src = s;
    alu_op = op; rd1 = a; rd2 = b; imm = i;
    in_valid = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clock);
      if (in_ready) begin
        bb = s ? i : b;
        e.res = alu_ref(op, a, bb);
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        inr = (a < DEPTH);
        if (w && inr) mref[a[AW-1:0]] = b;
        e.rdat = (r && inr) ? mref[a[AW-1:0]] : 32'd0;
        e.lat = r ? LAT : 0;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clock);
        #1;
        acc = cyc;
        done = 1'b1;
      end else begin
        @(posedge clock);
        #1;
      end
    end
    n_chk++;
    if (!done) begin
      n_err++;
      $display("FAIL issue_timeout: in_ready got 0 want 1");
    end
    in_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clock);
      if (sb.size() == 0 && !out_valid) ok = 1'b1;
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL drain: got %0d outstanding want 0", sb.size());
      sb.delete();
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, a0, a1;
    logic [31:0] ra, rb;
    bit w, r;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int k = 0; k < DEPTH; k++)
      issue(1, 0, 0, 3'd0, 32'(k), $urandom, 32'd0, acc);
    drain();

    issue(0, 0, 1, 3'b100, 32'd5, 32'd0, 32'd7, acc);
    @(negedge clock);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_result", result, 32'd12);
    @(posedge clock); #1;
    issue(0, 0, 0, 3'b001, 32'd3, 32'd3, 32'd0, acc);
    @(negedge clock);
    chk("sub_zero", 32'(zero), 32'd1);
    @(posedge clock); #1;
    issue(0, 0, 0, 3'b010, 32'd0, 32'd1, 32'd0, acc);
    @(negedge clock);
    chk("neg_result", result, 32'hFFFF_FFFF);
    chk("neg_flag", 32'(neg), 32'd1);
    @(posedge clock); #1;
    drain();

    issue(1, 0, 0, 3'd0, 32'd4, 32'd99, 32'd0, acc);
    issue(0, 1, 0, 3'd0, 32'd4, 32'd0, 32'd0, acc);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clock);
      chk("wait_in_ready", 32'(in_ready), 32'd0);
      chk("wait_out_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clock);
    chk("rd_valid", 32'(out_valid), 32'd1);
    chk("rd_data", read_data, 32'd99);
    @(posedge clock); #1;
    drain();

    bp_mode = 2;
    issue(0, 0, 0, 3'b011, 32'd41, 32'd0, 32'd0, acc);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'd42);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clock); #1;
    bp_mode = 0;
    a0 = 0;
    for (int k = 0; k < 10; k++) begin
      issue(0, 0, $urandom_range(0, 1), 3'b100, $urandom, $urandom,
            $urandom, acc);
      if (k == 0) a0 = acc;
    end
    chk("stream_rate", 32'(acc - a0), 32'd9);
    drain();

    issue(1, 0, 0, 3'd0, 32'd2, 32'h55, 32'd0, acc);
    issue(1, 0, 0, 3'd0, 32'(DEPTH + 2), 32'h77, 32'd0, acc);
    issue(0, 1, 0, 3'd0, 32'(DEPTH + 2), 32'd0, 32'd0, acc);
    issue(0, 1, 0, 3'd0, 32'd2, 32'd0, 32'd0, acc);
    issue(1, 1, 0, 3'd0, 32'd9, 32'd17, 32'd0, acc);
    drain();

    issue(0, 1, 0, 3'd0, 32'd4, 32'd0, 32'd0, acc);
    @(negedge clock);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    issue(0, 1, 0, 3'd0, 32'd4, 32'd0, 32'd0, acc);
    drain();

    bp_mode = 1;
    for (int k = 0; k < 200; k++) begin
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) == 0);
      ra = (w || r) ? 32'($urandom_range(0, DEPTH + 3)) : $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      issue(w, r, $urandom_range(0, 1), 3'($urandom_range(0, 7)),
            ra, rb, $urandom, a1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end
    drain();
    bp_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
